// File: rtl/seq_impl_checker.sv
// Runtime checker for the property (a ##N b) |-> c with N selected by `delay`.
// Keeps a short history of `a`, counts matches/failures and records the first failure.
module seq_impl_checker #(
    parameter int DELAY_MAX = 7,
    parameter int CNT_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [$clog2(DELAY_MAX+1)-1:0]     delay,
    input  logic                               a,
    input  logic                               b,
    input  logic                               c,
    input  logic                               clr_stats,
    output logic [CNT_W-1:0]                   match_cnt,
    output logic [CNT_W-1:0]                   fail_cnt,
    output logic                               fail,
    output logic                               fail_sticky,
    output logic [CNT_W-1:0]                   first_fail_cyc,
    output logic [CNT_W-1:0]                   cyc_cnt
);

    localparam int             DW   = $clog2(DELAY_MAX + 1);
    localparam logic [DW-1:0]  DMAX = DW'(DELAY_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    logic [DELAY_MAX:1] hist_q, hist_d;
    logic [DELAY_MAX:0] hist_ext_s;
    logic [DW-1:0]      delay_q, delay_d;
    logic [DW-1:0]      d_eff_s;
    logic               delay_chg_s;
    logic               match_s;
    logic               hit_s;
    logic               miss_s;

    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]   first_fail_cyc_q, first_fail_cyc_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic               fail_q, fail_d;
    logic               fail_sticky_q, fail_sticky_d;

    // Index 0 of the extended history is the live `a`, so delay==0 needs no special case.
    assign hist_ext_s = {hist_q, a};

    // Antecedent evaluation and history update
    always_comb begin
        if (delay > DMAX) begin
            d_eff_s = DMAX;
        end else begin
            d_eff_s = delay;
        end
        delay_d     = d_eff_s;
        delay_chg_s = en & (d_eff_s != delay_q);
        match_s     = en & b & ~delay_chg_s & hist_ext_s[d_eff_s];
        hit_s       = match_s & c & ~clr_stats;
        miss_s      = match_s & ~c & ~clr_stats;
        if (!en || delay_chg_s) begin
            hist_d = '0;
        end else begin
            hist_d = hist_ext_s[DELAY_MAX-1:0];
        end
    end

    // Statistics and failure reporting
    always_comb begin
        match_cnt_d      = match_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        first_fail_cyc_d = first_fail_cyc_q;
        cyc_cnt_d        = cyc_cnt_q;
        fail_sticky_d    = fail_sticky_q;
        fail_d           = 1'b0;
        if (clr_stats) begin
            match_cnt_d      = '0;
            fail_cnt_d       = '0;
            first_fail_cyc_d = '0;
            cyc_cnt_d        = '0;
            fail_sticky_d    = 1'b0;
        end else begin
            if (en) begin
                cyc_cnt_d = sat_inc(cyc_cnt_q);
            end else begin
                cyc_cnt_d = cyc_cnt_q;
            end
            if (hit_s) begin
                match_cnt_d = sat_inc(match_cnt_q);
            end else begin
                match_cnt_d = match_cnt_q;
            end
            if (miss_s) begin
                fail_cnt_d = sat_inc(fail_cnt_q);
                fail_d     = 1'b1;
                // Only the first failure since the last clear is timestamped.
                if (!fail_sticky_q) begin
                    fail_sticky_d    = 1'b1;
                    first_fail_cyc_d = cyc_cnt_q;
                end else begin
                    fail_sticky_d    = fail_sticky_q;
                end
            end else begin
                fail_cnt_d = fail_cnt_q;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q           <= '0;
            delay_q          <= '0;
            match_cnt_q      <= '0;
            fail_cnt_q       <= '0;
            first_fail_cyc_q <= '0;
            cyc_cnt_q        <= '0;
            fail_q           <= 1'b0;
            fail_sticky_q    <= 1'b0;
        end else begin
            hist_q           <= hist_d;
            delay_q          <= delay_d;
            match_cnt_q      <= match_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            first_fail_cyc_q <= first_fail_cyc_d;
            cyc_cnt_q        <= cyc_cnt_d;
            fail_q           <= fail_d;
            fail_sticky_q    <= fail_sticky_d;
        end
    end

    assign match_cnt      = match_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign fail           = fail_q;
    assign fail_sticky    = fail_sticky_q;
    assign first_fail_cyc = first_fail_cyc_q;
    assign cyc_cnt        = cyc_cnt_q;

endmodule

// File: tb/tb_seq_impl_checker.sv
// Randomised and directed bench for seq_impl_checker against a queue-based model.
module tb_seq_impl_checker;

    localparam int DELAY_MAX = 7;
    localparam int CNT_W     = 8;
    localparam int MAXV      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [2:0]       delay = 3'd0;
    logic             a = 1'b0;
    logic             b = 1'b0;
    logic             c = 1'b0;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] match_cnt, fail_cnt, first_fail_cyc, cyc_cnt;
    logic             fail, fail_sticky;

    int n_pass  = 0;
    int n_total = 0;

    seq_impl_checker #(.DELAY_MAX(DELAY_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .delay(delay),
        .a(a), .b(b), .c(c), .clr_stats(clr_stats),
        .match_cnt(match_cnt), .fail_cnt(fail_cnt), .fail(fail),
        .fail_sticky(fail_sticky), .first_fail_cyc(first_fail_cyc), .cyc_cnt(cyc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Model: a values since the last history clear, most recent first.
    int mq[$];
    int m_prev = 0, m_match = 0, m_fail = 0, m_cyc = 0, m_first = 0;
    bit m_sticky = 0, m_failp = 0;

    always @(posedge clk) begin : cmp
        int dly;
        bit chg, match, a_then;
        if (rst) begin
            mq.delete();
            m_prev = 0; m_match = 0; m_fail = 0; m_cyc = 0; m_first = 0;
            m_sticky = 0; m_failp = 0;
        end else begin
            dly   = (int'(delay) > DELAY_MAX) ? DELAY_MAX : int'(delay);
            chg   = en && (dly != m_prev);
            match = 0;
            if (en && !chg) begin
                if (dly == 0) a_then = a;
                else a_then = (mq.size() >= dly) ? (mq[dly-1] != 0) : 1'b0;
                match = b && a_then;
            end
            m_failp = match && !c && !clr_stats;
            if (clr_stats) begin
                m_match = 0; m_fail = 0; m_cyc = 0; m_first = 0; m_sticky = 0;
            end else begin
                if (match && !c && !m_sticky) begin
                    m_sticky = 1;
                    m_first  = m_cyc;
                end
                if (match && c)  m_match = sat(m_match + 1);
                if (match && !c) m_fail  = sat(m_fail + 1);
                if (en)          m_cyc   = sat(m_cyc + 1);
            end
            if (!en || chg) mq.delete();
            else begin
                mq.push_front(int'(a));
                if (mq.size() > DELAY_MAX) void'(mq.pop_back());
            end
            m_prev = dly;
        end
        #1;
        chk("match_cnt", int'(match_cnt), m_match);
        chk("fail_cnt", int'(fail_cnt), m_fail);
        chk("fail", int'(fail), int'(m_failp));
        chk("fail_sticky", int'(fail_sticky), int'(m_sticky));
        chk("first_fail_cyc", int'(first_fail_cyc), m_first);
        chk("cyc_cnt", int'(cyc_cnt), m_cyc);
    end

    task automatic drive(input bit en_i, input bit a_i, input bit b_i,
                         input bit c_i, input bit clr_i, input int d_i);
        en = en_i; a = a_i; b = b_i; c = c_i; clr_stats = clr_i; delay = 3'(d_i);
        @(posedge clk);
        #2;
    endtask

    // Reset lands mid-cycle, so the zeroed outputs prove it acts without a clock edge.
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; clr_stats = 1'b0;
        #1;
        chk("rst_match_cnt", int'(match_cnt), 0);
        chk("rst_fail_cnt", int'(fail_cnt), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_fail_sticky", int'(fail_sticky), 0);
        chk("rst_first_fail_cyc", int'(first_fail_cyc), 0);
        chk("rst_cyc_cnt", int'(cyc_cnt), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;

        // Single passing attempt, delay 1
        do_reset();
        for (int t = 0; t < 10; t++) drive(1, t == 5, t == 6, 1, 0, 1);
        chk("s36_match", int'(match_cnt), 1);
        chk("s36_fail_cnt", int'(fail_cnt), 0);
        chk("s36_sticky", int'(fail_sticky), 0);
        chk("s36_cyc", int'(cyc_cnt), 10);

        // Single failing attempt, delay 1
        do_reset();
        for (int t = 0; t < 7; t++) drive(1, t == 5, t == 6, t != 6, 0, 1);
        chk("s37_fail_pulse", int'(fail), 1);
        drive(1, 0, 0, 1, 0, 1);
        chk("s37_fail_gone", int'(fail), 0);
        chk("s37_fail_cnt", int'(fail_cnt), 1);
        chk("s37_sticky", int'(fail_sticky), 1);
        chk("s37_first", int'(first_fail_cyc), 6);

        // Overlapping attempts, delay 3
        do_reset();
        for (int t = 0; t < 10; t++) drive(1, t >= 2 && t <= 4, t >= 5 && t <= 7, 1, 0, 3);
        chk("s38_match", int'(match_cnt), 3);
        chk("s38_fail_cnt", int'(fail_cnt), 0);

        // Two failures, delay 0
        do_reset();
        for (int t = 0; t < 6; t++) drive(1, t == 2 || t == 4, t == 2 || t == 4, 0, 0, 0);
        chk("s39_fail_cnt", int'(fail_cnt), 2);
        chk("s39_first", int'(first_fail_cyc), 2);
        chk("s39_match", int'(match_cnt), 0);

        // Delay change suppresses evaluation and flushes history
        do_reset();
        for (int t = 0; t < 4; t++) drive(1, t == 3, 0, 1, 0, 2);
        drive(1, 0, 1, 0, 0, 1);
        chk("s40_match", int'(match_cnt), 0);
        chk("s40_fail_cnt", int'(fail_cnt), 0);
        chk("s40_fail", int'(fail), 0);
        drive(1, 0, 1, 0, 0, 1);
        chk("s40_fail_cnt_after", int'(fail_cnt), 0);

        // Reset between a and b, then clr_stats on a failing match
        do_reset();
        for (int t = 0; t < 3; t++) drive(1, t == 2, 0, 1, 0, 1);
        do_reset();
        drive(1, 0, 1, 0, 0, 1);
        chk("s41_no_pending", int'(fail_cnt), 0);
        drive(1, 1, 0, 1, 0, 1);
        drive(1, 0, 1, 0, 1, 1);
        chk("s41_fail", int'(fail), 0);
        chk("s41_fail_cnt", int'(fail_cnt), 0);
        chk("s41_sticky", int'(fail_sticky), 0);
        chk("s41_cyc", int'(cyc_cnt), 0);
        drive(1, 1, 0, 1, 1, 1);
        drive(1, 0, 1, 1, 0, 1);
        chk("clr_keeps_hist", int'(match_cnt), 1);
        chk("clr_cyc", int'(cyc_cnt), 1);

        // Saturation
        do_reset();
        for (int t = 0; t < 300; t++) drive(1, 1, 1, (t < 260) || ($urandom % 4 != 0), 0, 0);
        chk("sat_cyc", int'(cyc_cnt), MAXV);
        chk("sat_match", int'(match_cnt), MAXV);

        // Random traffic
        for (int blk = 0; blk < 4; blk++) begin
            int d;
            do_reset();
            d = $urandom % 8;
            for (int t = 0; t < 500; t++) begin
                if ($urandom % 30 == 0) d = $urandom % 8;
                drive($urandom % 20 != 0, $urandom % 2, $urandom % 2,
                      $urandom % 4 != 0, $urandom % 50 == 0, d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_impl_checker.md
SEQ_IMPL_CHECKER -- requirements
Module: seq_impl_checker

Interface
REQ-001 Parameter DELAY_MAX, default 7: largest supported ##N gap between antecedent terms `a` and `b`.
REQ-002 Parameter CNT_W, default 16: width of every statistics counter.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port en, input, 1: checker enable.
REQ-006 Port delay, input, $clog2(DELAY_MAX+1): gap N in `(a ##N b) |-> c`; range 0..DELAY_MAX.
REQ-007 Port a, input, 1: first antecedent term.
REQ-008 Port b, input, 1: second antecedent term.
REQ-009 Port c, input, 1: consequent, sampled in the same cycle as `b` (overlapping implication).
REQ-010 Port clr_stats, input, 1: synchronous clear of all statistics.
REQ-011 Port match_cnt, output, CNT_W: count of antecedent matches with `c`=1.
REQ-012 Port fail_cnt, output, CNT_W: count of antecedent matches with `c`=0.
REQ-013 Port fail, output, 1: one-cycle failure pulse.
REQ-014 Port fail_sticky, output, 1: set on the first failure; held until cleared.
REQ-015 Port first_fail_cyc, output, CNT_W: value of cyc_cnt at the first failure.
REQ-016 Port cyc_cnt, output, CNT_W: count of enabled cycles.

Function
REQ-017 SHALL keep a history register hist[1..DELAY_MAX]; while en=1, each cycle hist[1]<=a and hist[k]<=hist[k-1].
REQ-018 Antecedent match in cycle t SHALL be: en=1 and b=1 and (delay==0 ? a : hist[delay]).
REQ-019 On a match with c=1, match_cnt SHALL increment by 1.
REQ-020 On a match with c=0, fail_cnt SHALL increment by 1 and fail SHALL be 1 in cycle t+1 only (registered, latency 1).
REQ-021 On the first failure while fail_sticky=0, the block SHALL set fail_sticky and load first_fail_cyc with cyc_cnt as sampled in cycle t.
REQ-022 Later failures SHALL NOT change first_fail_cyc.
REQ-023 A cycle with no match SHALL be vacuous: no counter changes and no fail pulse.
REQ-024 Overlapping attempts SHALL each be evaluated independently; a=1 on consecutive cycles can yield a match on consecutive cycles.
REQ-025 cyc_cnt SHALL increment on every cycle with en=1.
REQ-026 All counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 With en=0, the block SHALL clear hist, perform no evaluation, and hold all counters.
REQ-028 If delay differs from its previous-cycle value while en=1, the block SHALL clear hist and SHALL NOT evaluate that cycle.
REQ-029 delay > DELAY_MAX SHALL be treated as DELAY_MAX.
REQ-030 clr_stats=1 SHALL zero match_cnt, fail_cnt, cyc_cnt, fail_sticky and first_fail_cyc next cycle.
REQ-031 clr_stats=1 SHALL leave hist unchanged.
REQ-032 A match in the same cycle as clr_stats SHALL be discarded: not counted, no fail pulse.

Reset
REQ-033 While rst=1, all outputs, hist and the stored previous delay SHALL be 0 immediately, independent of clk.
REQ-034 The first evaluation SHALL occur in the first posedge with rst=0 and en=1.
REQ-035 Reset asserted mid-operation SHALL discard pending attempts in hist; no fail pulse for them after release.

Verification
REQ-036 Scenario delay=1, c=1 constant, a=1 at cyc 5, b=1 at cyc 6 -> match_cnt=1, fail_cnt=0, fail never set.
REQ-037 Scenario delay=1, a=1 at cyc 5, b=1 and c=0 at cyc 6 -> fail=1 in cyc 7 only, fail_cnt=1, fail_sticky=1, first_fail_cyc=6.
REQ-038 Scenario delay=3, a=1 for cycles 2..4, b=1 for cycles 5..7, c=1 -> match_cnt=3.
REQ-039 Scenario delay=0, a=b=1 with c=0 in one cycle, then a second failure -> fail_cnt=2, first_fail_cyc unchanged from the first failure.
REQ-040 Scenario delay changed from 2 to 1 one cycle after a=1 -> no match that cycle, all counters unchanged.
REQ-041 Scenario rst pulsed between a=1 and b=1, then clr_stats coincident with a failing match -> no fail pulse, all counters 0, fail_sticky=0.
